// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, op-code encoding and the output-stage state type.
package alu_pkg;

   localparam int XLEN     = 32;
   localparam int ALU_OP_W = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLT  = 4'd2,
      ALU_SLTU = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_AND  = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_e;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_e;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU; undefined op codes produce zero.
module alu
   import alu_pkg::*;
(
   input  logic [XLEN-1:0]     i_op_a,
   input  logic [XLEN-1:0]     i_op_b,
   input  logic [ALU_OP_W-1:0] i_alu_op,
   output logic [XLEN-1:0]     o_result
);

   logic [4:0] shamt;
   assign shamt = i_op_b[4:0];

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      o_result = '0;
      case (i_alu_op)
         ALU_ADD:  o_result = i_op_a + i_op_b;
         ALU_SUB:  o_result = i_op_a - i_op_b;
         ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, $signed(i_op_a) < $signed(i_op_b)};
         ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, i_op_a < i_op_b};
         ALU_XOR:  o_result = i_op_a ^ i_op_b;
         ALU_OR:   o_result = i_op_a | i_op_b;
         ALU_AND:  o_result = i_op_a & i_op_b;
         ALU_SLL:  o_result = i_op_a << shamt;
         ALU_SRL:  o_result = i_op_a >> shamt;
         ALU_SRA:  o_result = $unsigned($signed(i_op_a) >>> shamt);
         default:  o_result = '0;
      endcase
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the pointer, grants one requester, advances past it on accept.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_enable,
   input  logic               i_advance,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_idx
);

   logic [ID_W-1:0] ptr_q;
   logic [ID_W-1:0] ptr_d;
   logic            found;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      found   = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         int cand;
         cand = int'(ptr_q) + off;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!found && i_req[cand]) begin
            found = 1'b1;
            o_idx = ID_W'(cand);
         end
      end
      if (i_enable && found) o_grant[o_idx] = 1'b1;
   end

   // Explicit wrap keeps the pointer in range when NUM_REQ is not a power of two.
   assign ptr_d = (o_idx == ID_W'(NUM_REQ - 1)) ? '0 : o_idx + ID_W'(1);

   always_ff @(posedge i_clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!i_rst_n)       ptr_q <= '0;
      else if (i_advance) ptr_q <= ptr_d;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ valid/ready requesters, with a one-entry tagged result register.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [NUM_REQ-1:0]           i_req_valid,
   input  logic [NUM_REQ*XLEN-1:0]      i_req_op_a,
   input  logic [NUM_REQ*XLEN-1:0]      i_req_op_b,
   input  logic [NUM_REQ*ALU_OP_W-1:0]  i_req_alu_op,
   output logic [NUM_REQ-1:0]           o_req_ready,
   output logic                         o_rsp_valid,
   output logic [ID_W-1:0]              o_rsp_id,
   output logic [XLEN-1:0]              o_rsp_data,
   input  logic                         i_rsp_ready
);

   rsp_state_e          state_q;
   logic [ID_W-1:0]     rsp_id_q;
   logic [XLEN-1:0]     rsp_data_q;

   logic                can_accept;
   logic                accept;
   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     grant_idx;
   logic [XLEN-1:0]     op_a_d;
   logic [XLEN-1:0]     op_b_d;
   logic [ALU_OP_W-1:0] alu_op_d;
   logic [XLEN-1:0]     rsp_data_d;

   // Gating with reset keeps ready low while the block is held in reset.
   assign can_accept = i_rst_n && ((state_q == RSP_EMPTY) || i_rsp_ready);
   assign accept     = |(grant & i_req_valid);

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_req     (i_req_valid),
      .i_enable  (can_accept),
      .i_advance (accept),
      .o_grant   (grant),
      .o_idx     (grant_idx)
   );

   assign op_a_d   = i_req_op_a[int'(grant_idx)*XLEN +: XLEN];
   assign op_b_d   = i_req_op_b[int'(grant_idx)*XLEN +: XLEN];
   assign alu_op_d = i_req_alu_op[int'(grant_idx)*ALU_OP_W +: ALU_OP_W];

   alu u_alu (
      .i_op_a   (op_a_d),
      .i_op_b   (op_b_d),
      .i_alu_op (alu_op_d),
      .o_result (rsp_data_d)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= RSP_EMPTY;
         rsp_id_q   <= '0;
         rsp_data_q <= '0;
      end else begin
         case (state_q)
            RSP_EMPTY: begin
               if (accept) begin
                  state_q    <= RSP_FULL;
                  rsp_id_q   <= grant_idx;
                  rsp_data_q <= rsp_data_d;
               end
            end
            RSP_FULL: begin
               // Drain and refill in one cycle keeps full throughput; a bare drain keeps data/id.
               if (i_rsp_ready) begin
                  if (accept) begin
                     rsp_id_q   <= grant_idx;
                     rsp_data_q <= rsp_data_d;
                  end else begin
                     state_q <= RSP_EMPTY;
                  end
               end
            end
            default: state_q <= RSP_EMPTY;
         endcase
      end
   end

   assign o_req_ready = grant;
   assign o_rsp_valid = (state_q == RSP_FULL);
   assign o_rsp_id    = rsp_id_q;
   assign o_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with two requesters and hand-computed expected results.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int NUM_REQ = 2;
   localparam int ID_W    = 1;

   logic                        clk = 1'b0;
   logic                        rst_n;
   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ*XLEN-1:0]     req_op_a;
   logic [NUM_REQ*XLEN-1:0]     req_op_b;
   logic [NUM_REQ*ALU_OP_W-1:0] req_alu_op;
   logic [NUM_REQ-1:0]          req_ready;
   logic                        rsp_valid;
   logic [ID_W-1:0]             rsp_id;
   logic [XLEN-1:0]             rsp_data;
   logic                        rsp_ready;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .i_req_op_a   (req_op_a),
      .i_req_op_b   (req_op_b),
      .i_req_alu_op (req_alu_op),
      .o_req_ready  (req_ready),
      .o_rsp_valid  (rsp_valid),
      .o_rsp_id     (rsp_id),
      .o_rsp_data   (rsp_data),
      .i_rsp_ready  (rsp_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic check_rsp(input string tag, input logic v, input logic [31:0] id,
                            input logic [31:0] data);
      check({tag, "_valid"}, 32'(rsp_valid), 32'(v));
      check({tag, "_id"},    32'(rsp_id),    id);
      check({tag, "_data"},  rsp_data,       data);
   endtask

   // Inputs change just after the falling edge; DUT outputs are sampled 1 ns later.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_req(input int k, input logic v, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
      req_valid[k]                 = v;
      req_alu_op[k*ALU_OP_W +: 4]  = op;
      req_op_a[k*XLEN +: XLEN]     = a;
      req_op_b[k*XLEN +: XLEN]     = b;
   endtask

   initial begin
      rst_n      = 1'b0;
      rsp_ready  = 1'b1;
      req_valid  = '0;
      req_op_a   = '0;
      req_op_b   = '0;
      req_alu_op = '0;
      set_req(0, 1'b1, ALU_ADD, 32'h0000_0005, 32'h0000_0003);

      // Reset state, with a request already pending
      tick(); tick(); #1;
      check("reset_ready", 32'(req_ready), 32'h0);
      check_rsp("reset", 1'b0, 0, 32'h0);

      // Single request: ADD 5+3
      tick(); rst_n = 1'b1; #1;
      check("single_ready", 32'(req_ready), 32'h1);
      tick(); set_req(0, 1'b0, ALU_ADD, 32'h5, 32'h3); #1;
      check_rsp("single", 1'b1, 0, 32'h0000_0008);
      check("single_idle_ready", 32'(req_ready), 32'h0);
      tick(); #1;
      check_rsp("drain_hold", 1'b0, 0, 32'h0000_0008);

      // Reset pulse returns the pointer to 0, then round-robin 0,1,0,1
      tick(); rst_n = 1'b0;
      tick(); rst_n = 1'b1;
      set_req(0, 1'b1, ALU_SUB, 32'h0000_0010, 32'h0000_0011);
      set_req(1, 1'b1, ALU_SRA, 32'h8000_0000, 32'h0000_0004);
      #1 check("rr_ready0", 32'(req_ready), 32'h1);
      tick(); #1;
      check_rsp("rr0", 1'b1, 0, 32'hFFFF_FFFF);
      check("rr_ready1", 32'(req_ready), 32'h2);
      tick(); #1;
      check_rsp("rr1", 1'b1, 1, 32'hF800_0000);
      check("rr_ready2", 32'(req_ready), 32'h1);
      tick(); #1;
      check_rsp("rr2", 1'b1, 0, 32'hFFFF_FFFF);
      check("rr_ready3", 32'(req_ready), 32'h2);
      tick(); req_valid = '0; #1;
      check_rsp("rr3", 1'b1, 1, 32'hF800_0000);

      // Backpressure: result held 3 cycles, then refill with no bubble
      tick(); rsp_ready = 1'b0;
      set_req(0, 1'b1, ALU_ADD, 32'h0000_0001, 32'h0000_0002);
      set_req(1, 1'b1, ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0);
      #1 check("bp_ready", 32'(req_ready), 32'h1);
      tick(); #1;
      check_rsp("bp_first", 1'b1, 0, 32'h0000_0003);
      for (int i = 0; i < 3; i++) begin
         check("bp_stall_ready", 32'(req_ready), 32'h0);
         check_rsp("bp_stall", 1'b1, 0, 32'h0000_0003);
         tick(); #1;
      end
      rsp_ready = 1'b1; #1;
      check("bp_release_ready", 32'(req_ready), 32'h2);
      tick(); req_valid = '0; #1;
      check_rsp("bp_next", 1'b1, 1, 32'h0000_FF00);
      tick();

      // Pointer hold: grant req1, idle 5 cycles, then req0 wins
      set_req(1, 1'b1, ALU_ADD, 32'h0000_0007, 32'h0000_0007);
      #1 check("ph_ready1", 32'(req_ready), 32'h2);
      tick(); req_valid = '0; #1;
      check_rsp("ph_grant1", 1'b1, 1, 32'h0000_000E);
      repeat (5) tick();
      #1 check("ph_idle_valid", 32'(rsp_valid), 32'h0);
      set_req(0, 1'b1, ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001);
      set_req(1, 1'b1, ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001);
      #1 check("ph_ready0", 32'(req_ready), 32'h1);

      // Edge ops
      tick(); #1;
      check_rsp("slt", 1'b1, 0, 32'h0000_0001);
      check("slt_next_ready", 32'(req_ready), 32'h2);
      tick();
      set_req(0, 1'b1, ALU_SLL, 32'h0000_0001, 32'h0000_0021);
      set_req(1, 1'b1, 4'hF,    32'h0000_0005, 32'h0000_0005);
      #1 check_rsp("sltu", 1'b1, 1, 32'h0000_0000);
      check("sll_ready", 32'(req_ready), 32'h1);
      tick(); #1;
      check_rsp("sll", 1'b1, 0, 32'h0000_0002);
      check("badop_ready", 32'(req_ready), 32'h2);
      tick();
      set_req(0, 1'b1, ALU_ADD, 32'h0000_0100, 32'h0000_0200);
      set_req(1, 1'b1, ALU_ADD, 32'h0000_0001, 32'h0000_0001);
      rsp_ready = 1'b0;
      #1 check_rsp("badop", 1'b1, 1, 32'h0000_0000);
      check("full_stall_ready", 32'(req_ready), 32'h0);

      // Reset while FULL: result discarded, pointer back to 0
      tick(); rst_n = 1'b0; #1;
      check("pre_reset_valid", 32'(rsp_valid), 32'h1);
      check("in_reset_ready", 32'(req_ready), 32'h0);
      tick(); #1;
      check_rsp("mid_reset", 1'b0, 0, 32'h0);
      check("mid_reset_ready", 32'(req_ready), 32'h0);
      rst_n = 1'b1; rsp_ready = 1'b1; #1;
      check("post_reset_ready", 32'(req_ready), 32'h1);
      tick(); req_valid = '0; #1;
      check_rsp("post_reset", 1'b1, 0, 32'h0000_0300);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
